// File: rtl/nonogram_grid_editor.sv
`default_nettype none
// ============================================================================
//  Module      : nonogram_grid_editor
//  Description : Cursor/edit front end of the nonogram player grid; drives
//                the paint and block bit-planes, lock handling and row clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module nonogram_grid_editor #(
  parameter int GRID_DIM = 10,
  parameter int CELLS    = GRID_DIM * GRID_DIM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       key_pulse,
  input  logic             lock,
  input  logic             clear_req,
  output logic [3:0]       sel_x,
  output logic [3:0]       sel_y,
  output logic [CELLS-1:0] paint,
  output logic [CELLS-1:0] block,
  output logic             event_off,
  output logic             edit_strobe,
  output logic [6:0]       paint_count
);

  typedef enum logic [1:0] {
    ST_EDIT   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [3:0]       c_last     = 4'(GRID_DIM - 1);
  localparam logic [CELLS-1:0] c_row_ones = {{(CELLS-GRID_DIM){1'b0}}, {GRID_DIM{1'b1}}};

  state_t           r_state, w_state_n;
  logic [3:0]       r_row, w_row_n;
  logic [3:0]       r_sel_x, w_sel_x_n;
  logic [3:0]       r_sel_y, w_sel_y_n;
  logic [CELLS-1:0] r_paint, w_paint_n;
  logic [CELLS-1:0] r_block, w_block_n;
  logic [6:0]       r_count, w_count_n;
  logic             r_strobe, w_strobe_n;

  logic [6:0]       w_cell;
  logic [6:0]       w_row_base;
  logic [CELLS-1:0] w_row_mask;
  logic [6:0]       w_row_pop;

  assign w_cell     = 7'(r_sel_y) * 7'(GRID_DIM) + 7'(r_sel_x);
  assign w_row_base = 7'(r_row) * 7'(GRID_DIM);
  assign w_row_mask = c_row_ones << w_row_base;
  assign w_row_pop  = 7'($countones(r_paint & w_row_mask));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_EDIT;
      r_row    <= 4'd0;
      r_sel_x  <= 4'd0;
      r_sel_y  <= 4'd0;
      r_paint  <= '0;
      r_block  <= '0;
      r_count  <= 7'd0;
      r_strobe <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_row    <= w_row_n;
      r_sel_x  <= w_sel_x_n;
      r_sel_y  <= w_sel_y_n;
      r_paint  <= w_paint_n;
      r_block  <= w_block_n;
      r_count  <= w_count_n;
      r_strobe <= w_strobe_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_row_n    = r_row;
    w_sel_x_n  = r_sel_x;
    w_sel_y_n  = r_sel_y;
    w_paint_n  = r_paint;
    w_block_n  = r_block;
    w_count_n  = r_count;
    w_strobe_n = 1'b0;
    case (r_state)
      ST_EDIT: begin
        if (clear_req) begin
          w_state_n = ST_CLEAR;
          w_row_n   = 4'd0;
        end else if (lock) begin
          w_state_n = ST_LOCKED;
        end else if (key_pulse[4]) begin
          // Cell cycles empty -> painted -> blocked -> empty.
          w_strobe_n = 1'b1;
          if (r_paint[w_cell]) begin
            w_paint_n[w_cell] = 1'b0;
            w_block_n[w_cell] = 1'b1;
            w_count_n         = r_count - 7'd1;
          end else if (r_block[w_cell]) begin
            w_block_n[w_cell] = 1'b0;
          end else begin
            w_paint_n[w_cell] = 1'b1;
            w_count_n         = r_count + 7'd1;
          end
        end else if (key_pulse[0]) begin
          w_sel_y_n = (r_sel_y == 4'd0) ? c_last : r_sel_y - 4'd1;
        end else if (key_pulse[1]) begin
          w_sel_y_n = (r_sel_y == c_last) ? 4'd0 : r_sel_y + 4'd1;
        end else if (key_pulse[2]) begin
          w_sel_x_n = (r_sel_x == 4'd0) ? c_last : r_sel_x - 4'd1;
        end else if (key_pulse[3]) begin
          w_sel_x_n = (r_sel_x == c_last) ? 4'd0 : r_sel_x + 4'd1;
        end
      end
      ST_CLEAR: begin
        w_paint_n = r_paint & ~w_row_mask;
        w_block_n = r_block & ~w_row_mask;
        w_count_n = r_count - w_row_pop;
        if (r_row == c_last) begin
          w_row_n   = 4'd0;
          w_sel_x_n = 4'd0;
          w_sel_y_n = 4'd0;
          w_state_n = lock ? ST_LOCKED : ST_EDIT;
        end else begin
          w_row_n = r_row + 4'd1;
        end
      end
      ST_LOCKED: begin
        if (clear_req) begin
          w_state_n = ST_CLEAR;
          w_row_n   = 4'd0;
        end else if (!lock) begin
          w_state_n = ST_EDIT;
        end
      end
      default: w_state_n = ST_EDIT;
    endcase
  end

  assign sel_x       = r_sel_x;
  assign sel_y       = r_sel_y;
  assign paint       = r_paint;
  assign block       = r_block;
  assign paint_count = r_count;
  assign edit_strobe = r_strobe;
  assign event_off   = (r_state != ST_EDIT);

endmodule
`default_nettype wire

// File: tb/tb_nonogram_grid_editor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nonogram_grid_editor
//  Description : Self-checking bench: directed vector table, hand sequences
//                and random stimulus against a cell-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nonogram_grid_editor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  key_pulse = 5'd0;
  logic        lock = 1'b0;
  logic        clear_req = 1'b0;
  logic [3:0]  sel_x, sel_y;
  logic [99:0] paint, block;
  logic        event_off, edit_strobe;
  logic [6:0]  paint_count;

  nonogram_grid_editor #(.GRID_DIM(10), .CELLS(100)) dut (
    .clk(clk), .rst(rst), .key_pulse(key_pulse), .lock(lock),
    .clear_req(clear_req), .sel_x(sel_x), .sel_y(sel_y), .paint(paint),
    .block(block), .event_off(event_off), .edit_strobe(edit_strobe),
    .paint_count(paint_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-cell state 0 empty, 1 painted, 2 blocked.
  int m_cell[100];
  int m_x, m_y, m_mode, m_row;
  bit m_strobe;

  typedef struct {
    logic       r;
    logic [4:0] key;
    logic       lk;
    logic       cl;
    logic [3:0] ex_x;
    logic [3:0] ex_y;
    logic [6:0] ex_cnt;
    logic       ex_str;
    logic       ex_off;
    int         idx;
    logic       ex_p;
    logic       ex_b;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [4:0] k, input logic lk, input logic cl);
    m_strobe = 1'b0;
    if (r) begin
      foreach (m_cell[i]) m_cell[i] = 0;
      m_x = 0; m_y = 0; m_mode = 0; m_row = 0;
    end else if (m_mode == 0) begin
      if (cl) begin m_mode = 1; m_row = 0; end
      else if (lk) m_mode = 2;
      else if (k[4]) begin
        m_cell[m_y*10 + m_x] = (m_cell[m_y*10 + m_x] + 1) % 3;
        m_strobe = 1'b1;
      end
      else if (k[0]) m_y = (m_y + 9) % 10;
      else if (k[1]) m_y = (m_y + 1) % 10;
      else if (k[2]) m_x = (m_x + 9) % 10;
      else if (k[3]) m_x = (m_x + 1) % 10;
    end else if (m_mode == 1) begin
      for (int c = 0; c < 10; c++) m_cell[m_row*10 + c] = 0;
      if (m_row == 9) begin
        m_row = 0; m_x = 0; m_y = 0;
        m_mode = lk ? 2 : 0;
      end else m_row++;
    end else begin
      if (cl) begin m_mode = 1; m_row = 0; end
      else if (!lk) m_mode = 0;
    end
  endtask

  task automatic check_model();
    logic [99:0] ep, eb;
    int cnt;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      ep[i] = (m_cell[i] == 1);
      eb[i] = (m_cell[i] == 2);
      if (m_cell[i] == 1) cnt++;
    end
    chk("sel_x", 128'(sel_x), 128'(m_x));
    chk("sel_y", 128'(sel_y), 128'(m_y));
    chk("paint", 128'(paint), 128'(ep));
    chk("block", 128'(block), 128'(eb));
    chk("paint_count", 128'(paint_count), 128'(cnt));
    chk("event_off", 128'(event_off), 128'(m_mode != 0));
    chk("edit_strobe", 128'(edit_strobe), 128'(m_strobe));
    chk("paint_and_block_disjoint", 128'(paint & block), 128'(0));
  endtask

  task automatic step(input logic r, input logic [4:0] k, input logic lk, input logic cl);
    rst = r; key_pulse = k; lock = lk; clear_req = cl;
    @(posedge clk);
    #1;
    model_step(r, k, lk, cl);
    check_model();
  endtask

  task automatic press(input logic [4:0] k, input int n, input logic lk);
    for (int i = 0; i < n; i++) step(1'b0, k, lk, 1'b0);
  endtask

  initial begin
    logic l_lk;
    logic [4:0] l_k;
    //            r  key       lk cl  x  y  cnt str off idx p b
    tbl[0]  = '{1'b1, 5'b00000, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0};
    tbl[1]  = '{1'b0, 5'b10000, 0, 0, 0, 0, 1, 1, 0,  0, 1, 0};
    tbl[2]  = '{1'b0, 5'b10000, 0, 0, 0, 0, 0, 1, 0,  0, 0, 1};
    tbl[3]  = '{1'b0, 5'b10000, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0};
    tbl[4]  = '{1'b0, 5'b00100, 0, 0, 9, 0, 0, 0, 0,  0, 0, 0};
    tbl[5]  = '{1'b0, 5'b00001, 0, 0, 9, 9, 0, 0, 0,  0, 0, 0};
    tbl[6]  = '{1'b0, 5'b01000, 0, 0, 0, 9, 0, 0, 0,  0, 0, 0};
    tbl[7]  = '{1'b0, 5'b01000, 0, 0, 1, 9, 0, 0, 0,  0, 0, 0};
    tbl[8]  = '{1'b0, 5'b10000, 0, 0, 1, 9, 1, 1, 0, 91, 1, 0};
    tbl[9]  = '{1'b0, 5'b00000, 0, 0, 1, 9, 1, 0, 0, 91, 1, 0};
    tbl[10] = '{1'b0, 5'b10101, 0, 0, 1, 9, 0, 1, 0, 91, 0, 1};
    tbl[11] = '{1'b0, 5'b01010, 0, 0, 1, 0, 0, 0, 0, 91, 0, 1};
    tbl[12] = '{1'b0, 5'b10000, 1, 0, 1, 0, 0, 0, 1,  1, 0, 0};
    tbl[13] = '{1'b0, 5'b10000, 1, 0, 1, 0, 0, 0, 1,  1, 0, 0};
    tbl[14] = '{1'b0, 5'b10000, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0};
    tbl[15] = '{1'b0, 5'b10000, 0, 0, 1, 0, 1, 1, 0,  1, 1, 0};

    for (int v = 0; v < 16; v++) begin
      step(tbl[v].r, tbl[v].key, tbl[v].lk, tbl[v].cl);
      chk($sformatf("tbl%0d_sel_x", v), 128'(sel_x), 128'(tbl[v].ex_x));
      chk($sformatf("tbl%0d_sel_y", v), 128'(sel_y), 128'(tbl[v].ex_y));
      chk($sformatf("tbl%0d_count", v), 128'(paint_count), 128'(tbl[v].ex_cnt));
      chk($sformatf("tbl%0d_strobe", v), 128'(edit_strobe), 128'(tbl[v].ex_str));
      chk($sformatf("tbl%0d_event_off", v), 128'(event_off), 128'(tbl[v].ex_off));
      chk($sformatf("tbl%0d_paint_bit", v), 128'(paint[tbl[v].idx]), 128'(tbl[v].ex_p));
      chk($sformatf("tbl%0d_block_bit", v), 128'(block[tbl[v].idx]), 128'(tbl[v].ex_b));
    end

    // Paint 0, 55, 99 then clear with keys hammering during the clear.
    step(1'b1, 5'd0, 1'b0, 1'b0);
    press(5'b10000, 1, 1'b0);
    press(5'b00010, 5, 1'b0);
    press(5'b01000, 5, 1'b0);
    press(5'b10000, 1, 1'b0);
    press(5'b00010, 4, 1'b0);
    press(5'b01000, 4, 1'b0);
    press(5'b10000, 1, 1'b0);
    chk("three_painted_count", 128'(paint_count), 128'(3));
    chk("three_painted_bits", 128'(paint), 128'((100'd1 << 99) | (100'd1 << 55) | 100'd1));
    step(1'b0, 5'b10000, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 5'(1 << (i % 5)), 1'b0, 1'(i == 3));
      chk("clear_event_off", 128'(event_off), 128'(1));
      chk("clear_no_strobe", 128'(edit_strobe), 128'(0));
    end
    step(1'b0, 5'd0, 1'b0, 1'b0);
    chk("clear_done_paint", 128'(paint), 128'(0));
    chk("clear_done_count", 128'(paint_count), 128'(0));
    chk("clear_done_cursor", 128'({sel_x, sel_y}), 128'(0));
    chk("clear_done_edit", 128'(event_off), 128'(0));

    // Lock, clear while locked, then unlock.
    press(5'b10000, 1, 1'b0);
    step(1'b0, 5'd0, 1'b1, 1'b0);
    press(5'b10000, 2, 1'b1);
    chk("locked_no_edit", 128'(paint), 128'(1));
    step(1'b0, 5'd0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 5'b10000, 1'b1, 1'b0);
    chk("clear_back_to_locked", 128'(event_off), 128'(1));
    chk("clear_locked_paint", 128'(paint), 128'(0));
    step(1'b0, 5'd0, 1'b0, 1'b0);
    press(5'b10000, 1, 1'b0);
    chk("unlocked_edit", 128'(paint), 128'(1));

    // Reset in the 4th CLEAR cycle with row 9 still populated.
    press(5'b00001, 1, 1'b0);
    press(5'b10000, 1, 1'b0);
    step(1'b0, 5'd0, 1'b0, 1'b1);
    press(5'd0, 3, 1'b0);
    chk("partial_clear_row9_kept", 128'(paint[90]), 128'(1));
    step(1'b1, 5'd0, 1'b0, 1'b0);
    chk("abort_paint", 128'(paint), 128'(0));
    chk("abort_block", 128'(block), 128'(0));
    chk("abort_event_off", 128'(event_off), 128'(0));
    chk("abort_count", 128'(paint_count), 128'(0));

    // Randomized traffic checked against the model.
    l_lk = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) l_lk = ~l_lk;
      l_k = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      step(1'($urandom_range(0, 399) == 0), l_k, l_lk, 1'($urandom_range(0, 99) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nonogram_grid_editor.md
Name: nonogram_grid_editor

Overview:
Writer side of the player grid consumed by the nonogram game block. It turns single-cycle key pulses into cursor moves and cell edits, and maintains the paint and block bit-planes that the game compares against the level solution. It also handles lock (game over) and a multi-cycle row-by-row grid clear for a level change.

Parameters:
GRID_DIM, 10, grid edge length; cells are GRID_DIM*GRID_DIM, and only 10 is supported.
CELLS, 100, GRID_DIM*GRID_DIM; width of the paint and block buses.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
key_pulse  in  5  one-cycle key strobes: [0] up, [1] down, [2] left, [3] right, [4] action
lock  in  1  level solved or game over; editing is disabled while high
clear_req  in  1  one-cycle request to wipe the grid (new level)
sel_x  out  4  cursor column, 0..9
sel_y  out  4  cursor row, 0..9
paint  out  100  painted cells, bit index = sel_y*10 + sel_x
block  out  100  blocked (X-marked) cells, same indexing
event_off  out  1  high whenever keys are ignored (state CLEAR or LOCKED)
edit_strobe  out  1  one-cycle pulse on the cycle a cell change becomes visible
paint_count  out  7  number of set bits in paint, 0..100

Behaviour:
- Reset, sampled at a clk edge with rst=1:
  - paint=0, block=0, sel_x=0, sel_y=0, paint_count=0, edit_strobe=0.
  - state=EDIT, event_off=0, row counter=0.
  - Reset has priority over every other input.
- States: EDIT, CLEAR, LOCKED. event_off is 1 in CLEAR and LOCKED (registered, follows state).
- EDIT, per cycle:
  - Exactly one key is processed.
  - Priority: action > up > down > left > right. Lower-priority bits in the same cycle are dropped, not queued.
- Cursor moves take effect the next cycle:
  - up: sel_y-1. down: sel_y+1. left: sel_x-1. right: sel_x+1.
  - Wrap-around: 0-1 becomes 9, and 9+1 becomes 0.
- Action on cell i = sel_y*10+sel_x cycles its state:
  - empty -> painted: paint[i] set.
  - painted -> blocked: paint[i] cleared, block[i] set.
  - blocked -> empty: block[i] cleared.
  - The update is visible the next cycle. edit_strobe is 1 that same cycle.
  - paint_count is updated in the same cycle: +1 on empty->painted, -1 on painted->blocked, unchanged on blocked->empty.
- Invariant: (paint & block) == 0 at all times. A bench checks it every cycle.
- Transitions, in precedence order:
  - clear_req=1 in any state (EDIT or LOCKED) -> CLEAR; key_pulse in that cycle is ignored.
  - In EDIT, lock=1 -> LOCKED; key_pulse in that cycle is ignored.
  - In LOCKED, lock=0 and clear_req=0 -> EDIT; keys are accepted from the following cycle.
- CLEAR (multi-cycle):
  - Row counter r runs 0..9, one row per cycle: paint[r*10+9 : r*10]=0 and block[r*10+9 : r*10]=0.
  - paint_count is decremented by the number of painted bits removed from that row.
  - After row 9 is cleared (10 cycles in CLEAR), the next cycle has sel_x=0, sel_y=0, r=0, paint_count=0.
  - On exit, the next state is LOCKED if lock=1, else EDIT.
- During CLEAR, clear_req and lock are ignored and the clear is not restarted.
- Keys are never buffered. Any key arriving in CLEAR or LOCKED is lost.
- edit_strobe is never asserted in CLEAR or LOCKED, nor for cursor-only moves.
- Reset mid-CLEAR aborts the sequence: the whole grid is zeroed in one cycle and the state becomes EDIT.

Test Plan:
- Reset, then action at (0,0) -> next cycle paint[0]=1, edit_strobe=1, paint_count=1. A second action gives paint[0]=0, block[0]=1, count=0. A third action makes cell 0 empty.
- Cursor at (0,0): left -> sel_x=9. up -> sel_y=9. right twice -> sel_x=1. Then action -> paint[91]=1.
- key_pulse=5'b10101 at (3,2) -> only the action is taken: paint[23]=1, cursor unchanged. Next, key_pulse=5'b01010 -> sel_y=3 only, sel_x stays 3.
- Paint cells 0, 55 and 99 (count=3), pulse clear_req -> event_off=1 for 10 cycles, keys during that window are ignored. After the 10th cycle paint=block=0, count=0, cursor at (0,0), state EDIT.
- lock=1 -> event_off=1 and an action does not change the grid. clear_req while locked -> full clear, then back to LOCKED because lock is still 1. lock=0 -> EDIT and keys work again.
- rst=1 at the 4th cycle of CLEAR with the grid partially cleared -> next cycle paint=block=0, event_off=0, count=0.
